// File: rtl/cmos_capture_pack.sv
// rtl/cmos_capture_pack.sv - DVP byte packer with start-up frame skip, line timing and partial-pixel flag
// Optional port frame_cnt_o when CAPTURE_FRAME_CNT_EN is defined.
module cmos_capture_pack #(
    parameter int IN_W        = 8,
    parameter int BPP         = 2,
    parameter int SKIP_FRAMES = 10,
    parameter int CNT_W       = 12
) (
    input  logic                 pclk,
    input  logic                 rst_n,
    input  logic [IN_W-1:0]      pdata_i,
    input  logic                 de_i,
    input  logic                 vs_i,
    input  logic                 byte_swap,
    input  logic                 rgb_swap,
    output logic [IN_W*BPP-1:0]  pdata_o,
    output logic                 de_o,
    output logic                 vs_o,
    output logic                 sof_o,
    output logic                 eol_o,
    output logic [CNT_W-1:0]     x_cnt_o,
    output logic [CNT_W-1:0]     y_cnt_o,
    output logic [CNT_W-1:0]     line_len_o,
    output logic                 err_partial_o,
`ifdef CAPTURE_FRAME_CNT_EN
    output logic [15:0]          frame_cnt_o,
`endif
    output logic                 armed_o
);

    localparam int OW = IN_W * BPP;
    localparam int BW = (BPP > 1) ? $clog2(BPP) : 1;
    localparam logic [BW-1:0] LAST = BW'(BPP - 1);

    typedef enum logic [1:0] {WAIT_VS, SKIP, RUN} state_t;

    state_t          state, state_nx;
    logic [7:0]      skip_cnt, skip_nx;
    logic            vs_r, vs_d, de_r, de_d;
    logic [IN_W-1:0] pd_r;
    logic [BW-1:0]   b_idx;
    logic [CNT_W-1:0] x;
    logic            vs_rise, de_fall, enter_run, run_act;
    logic [OW-1:0]   beats, word, word_sw;

    assign vs_rise = vs_r & ~vs_d;
    assign de_fall = ~de_r & de_d;
    assign run_act = (state == RUN) | enter_run;
    assign armed_o = (state == RUN);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_r <= 1'b0;
            vs_d <= 1'b0;
            de_r <= 1'b0;
            de_d <= 1'b0;
            pd_r <= '0;
        end else begin
            vs_r <= vs_i;
            vs_d <= vs_r;
            de_r <= de_i;
            de_d <= de_r;
            pd_r <= pdata_i;
        end
    end

    always_comb begin
        state_nx  = state;
        skip_nx   = skip_cnt;
        enter_run = 1'b0;
        case (state)
            WAIT_VS: if (vs_rise) begin
                if (SKIP_FRAMES == 0) begin
                    state_nx  = RUN;
                    enter_run = 1'b1;
                end else begin
                    state_nx = SKIP;
                end
            end
            SKIP: if (vs_rise) begin
                skip_nx = skip_cnt + 8'd1;
                if (skip_nx == 8'(SKIP_FRAMES)) begin
                    state_nx  = RUN;
                    enter_run = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Beat i of the pixel sits at beats[i*IN_W +: IN_W]; the final beat comes straight from pd_r.
    generate
        if (BPP > 1) begin : g_slots
            logic [(BPP-1)*IN_W-1:0] slot_bus;
            always_ff @(posedge pclk) begin
                if (de_r && b_idx != LAST)
                    slot_bus[b_idx*IN_W +: IN_W] <= pd_r;
            end
            assign beats = {pd_r, slot_bus};
        end else begin : g_noslot
            assign beats = pd_r;
        end
    endgenerate

    always_comb begin
        word = '0;
        for (int i = 0; i < BPP; i++) begin
            if (byte_swap)
                word[i*IN_W +: IN_W] = beats[i*IN_W +: IN_W];
            else
                word[(BPP-1-i)*IN_W +: IN_W] = beats[i*IN_W +: IN_W];
        end
    end

    generate
        if (IN_W == 8 && BPP == 2) begin : g_rgb
            assign word_sw = rgb_swap ? {word[4:0], word[10:5], word[15:11]} : word;
        end else begin : g_norgb
            assign word_sw = word;
        end
    endgenerate

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= WAIT_VS;
            skip_cnt      <= '0;
            b_idx         <= '0;
            x             <= '0;
            pdata_o       <= '0;
            de_o          <= 1'b0;
            vs_o          <= 1'b0;
            sof_o         <= 1'b0;
            eol_o         <= 1'b0;
            x_cnt_o       <= '0;
            y_cnt_o       <= '0;
            line_len_o    <= '0;
            err_partial_o <= 1'b0;
`ifdef CAPTURE_FRAME_CNT_EN
            frame_cnt_o   <= '0;
`endif
        end else begin
            state    <= state_nx;
            skip_cnt <= skip_nx;
            de_o     <= 1'b0;
            sof_o    <= 1'b0;
            eol_o    <= 1'b0;
            vs_o     <= vs_r & run_act;
            // A frame start takes priority over any beat arriving in the same cycle.
            if (vs_rise && run_act) begin
                sof_o   <= 1'b1;
                x       <= '0;
                x_cnt_o <= '0;
                y_cnt_o <= '0;
                b_idx   <= '0;
`ifdef CAPTURE_FRAME_CNT_EN
                frame_cnt_o <= frame_cnt_o + 16'd1;
`endif
            end else if (state == RUN) begin
                if (de_r) begin
                    if (b_idx == LAST) begin
                        pdata_o <= word_sw;
                        de_o    <= 1'b1;
                        x_cnt_o <= x;
                        b_idx   <= '0;
                        if (x != '1)
                            x <= x + 1'b1;
                    end else begin
                        b_idx <= b_idx + BW'(1);
                    end
                end else if (de_fall) begin
                    eol_o      <= 1'b1;
                    line_len_o <= x;
                    x          <= '0;
                    x_cnt_o    <= '0;
                    b_idx      <= '0;
                    if (y_cnt_o != '1)
                        y_cnt_o <= y_cnt_o + 1'b1;
                    if (b_idx != '0)
                        err_partial_o <= 1'b1;
                end
            end
        end
    end

endmodule
